// File: rtl/sc_decoder_pkg.sv
// Shared definitions for the SC decoder datapath: default code size and the
// polar butterfly used by the partial-sum unit and the g-function stage.
package sc_decoder_pkg;

  localparam int LOG_N_DEFAULT = 10;
  localparam int MAX_LOG_N     = 12;
  localparam int N             = 1 << LOG_N_DEFAULT;
  localparam int PSUM_W        = N - 1;
  localparam int MAX_HALF      = 1 << (MAX_LOG_N - 1);

  typedef logic [MAX_HALF-1:0]   half_t;
  typedef logic [2*MAX_HALF-1:0] full_t;

  // Bit offset of level l inside the flattened partial-sum bus.
  function automatic int psum_offset(input int l);
    return (1 << l) - 1;
  endfunction

  // encode(a||b) from enc(a) and enc(b), each 'half' bits wide. The low half
  // of the result is xa^xb and the high half is xb, since a holds the lower
  // indices. Inputs must be zero above 'half'.
  function automatic full_t polar_combine(input half_t xa, input half_t xb,
                                          input int half);
    full_t lo;
    full_t hi;
    lo = {{MAX_HALF{1'b0}}, xa ^ xb};
    hi = {{MAX_HALF{1'b0}}, xb} << half;
    return lo | hi;
  endfunction

endpackage

// File: rtl/sc_partial_sum_unit_if.sv
// Bit-stream and partial-sum bus between the bit decider, the partial-sum
// unit and its consumers (LLR array, frame output buffer).
interface sc_partial_sum_unit_if #(
  parameter int LOG_N = 10
);
  localparam int N      = 1 << LOG_N;
  localparam int PSUM_W = N - 1;

  logic              frame_start;
  logic              decoded_bit;
  logic              bit_valid;
  logic [LOG_N-1:0]  bit_index;
  logic [PSUM_W-1:0] psum_flat;
  logic [N-1:0]      codeword;
  logic              frame_done;

  modport master (
    output frame_start, decoded_bit, bit_valid,
    input  bit_index, psum_flat, codeword, frame_done
  );

  modport slave (
    input  frame_start, decoded_bit, bit_valid,
    output bit_index, psum_flat, codeword, frame_done
  );

endinterface

// File: rtl/sc_psum_level.sv
// One level of the partial-sum tree: holds the left-block encode W_L and the
// PSUM_L register, and emits the combined encode for the level above.
module sc_psum_level
  import sc_decoder_pkg::*;
#(
  parameter int L = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [L:0]          idx,
  input  logic                accept,
  input  logic                clear_w,
  input  logic                clear_psum,
  input  logic [(1<<L)-1:0]   enc_in,
  output logic [(2<<L)-1:0]   enc_out,
  output logic [(1<<L)-1:0]   psum
);

  localparam int W = 1 << L;

  logic [W-1:0] w_acc;
  logic         block_done;
  logic         load;

  // A level-L block ends when the low L index bits are all ones.
  generate
    if (L == 0) begin : g_leaf
      assign block_done = 1'b1;
    end else begin : g_inner
      assign block_done = &idx[L-1:0];
    end
  endgenerate

  assign load    = accept & block_done & ~idx[L];
  assign enc_out = (2*W)'(polar_combine(half_t'(w_acc), half_t'(enc_in), W));

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_acc <= '0;
      psum  <= '0;
    end else begin
      if (load)         w_acc <= enc_in;
      else if (clear_w) w_acc <= '0;

      if (load)            psum <= enc_in;
      else if (clear_psum) psum <= '0;
    end
  end

endmodule

// File: rtl/sc_partial_sum_unit.sv
// Partial-sum unit: tracks the bit index, runs the per-level encode chain in
// a single cycle and captures the full-frame codeword on the last bit.
module sc_partial_sum_unit
  import sc_decoder_pkg::*;
#(
  parameter int LOG_N = LOG_N_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  sc_partial_sum_unit_if.slave bus
);

  localparam int FRAME_N = 1 << LOG_N;
  localparam int CHAIN_W = 2 * FRAME_N - 1;

  logic [LOG_N-1:0]   bit_index_q;
  logic [FRAME_N-1:0] codeword_q;
  logic               frame_done_q;
  logic [LOG_N-1:0]   cur_index;
  logic               accept;
  logic               last_bit;
  logic               clear_w;

  // chain holds encode of the block ending at cur_index for every level,
  // laid out like psum_flat with one extra top level of FRAME_N bits.
  wire [CHAIN_W-1:0]  chain;
  wire [FRAME_N-2:0]  psum_bus;

  // frame_start clears first, so a coincident valid bit is taken as u_0.
  assign cur_index = bus.frame_start ? '0 : bit_index_q;
  assign accept    = bus.bit_valid;
  assign last_bit  = accept & (&cur_index);
  assign clear_w   = bus.frame_start | last_bit;
  assign chain[0]  = bus.decoded_bit;

  generate
    for (genvar l = 0; l < LOG_N; l++) begin : g_level
      sc_psum_level #(.L(l)) u_level (
        .clk        (clk),
        .rst        (rst),
        .idx        (cur_index[l:0]),
        .accept     (accept),
        .clear_w    (clear_w),
        .clear_psum (bus.frame_start),
        .enc_in     (chain[psum_offset(l) +: (1 << l)]),
        .enc_out    (chain[psum_offset(l + 1) +: (2 << l)]),
        .psum       (psum_bus[psum_offset(l) +: (1 << l)])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_index_q  <= '0;
      codeword_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_bit;
      if (accept) begin
        // The increment wraps to 0 after bit N-1.
        bit_index_q <= cur_index + LOG_N'(1);
        if (last_bit) codeword_q <= chain[FRAME_N-1 +: FRAME_N];
      end else if (bus.frame_start) begin
        bit_index_q <= '0;
      end
    end
  end

  assign bus.bit_index  = bit_index_q;
  assign bus.psum_flat  = psum_bus;
  assign bus.codeword   = codeword_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sc_partial_sum_unit.sv
// Bench for sc_partial_sum_unit: directed LOG_N=3 vectors with literal
// expectations plus a LOG_N=10 random run, both checked against a model.
module tb_sc_partial_sum_unit;

  localparam int SLG = 3;
  localparam int LLG = 10;
  localparam int MW  = 1024;

  typedef struct {
    int          idx;
    logic [MW-1:0] u;
    logic [MW-1:0] psum;
    logic [MW-1:0] cw;
    logic        done;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sc_partial_sum_unit_if #(.LOG_N(SLG)) s_if ();
  sc_partial_sum_unit_if #(.LOG_N(LLG)) l_if ();

  sc_partial_sum_unit #(.LOG_N(SLG)) dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));
  sc_partial_sum_unit #(.LOG_N(LLG)) dut_l (.clk(clk), .rst(rst), .bus(l_if.slave));

  task automatic check(input string name, input logic [MW-1:0] got,
                       input logic [MW-1:0] exp);
    int d;
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      d = -1;
      for (int i = MW - 1; i >= 0; i--) if (got[i] !== exp[i]) d = i;
      $display("FAIL %s: got %h required %h (lowest differing bit %0d)",
               name, got[63:0], exp[63:0], d);
    end
  endtask

  // x_k = XOR of u[base+i] over all i < len with (i & k) == k.
  function automatic logic [MW-1:0] encode(input logic [MW-1:0] u,
                                           input int base, input int len);
    logic [MW-1:0] x = '0;
    for (int k = 0; k < len; k++)
      for (int i = k; i < len; i++)
        if ((i & k) == k) x[k] = x[k] ^ u[base + i];
    return x;
  endfunction

  function automatic model_t model_zero();
    model_t m;
    m.idx = 0; m.u = '0; m.psum = '0; m.cw = '0; m.done = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input int lg,
                                        input logic fs, input logic v,
                                        input logic b);
    int n = 1 << lg;
    int len;
    logic [MW-1:0] e;
    m.done = 1'b0;
    if (fs) begin
      m.idx = 0; m.u = '0; m.psum = '0;
    end
    if (v) begin
      m.u[m.idx] = b;
      for (int l = 0; l < lg; l++) begin
        len = 1 << l;
        if (((m.idx + 1) % len == 0) && ((m.idx / len) % 2 == 0)) begin
          e = encode(m.u, m.idx - len + 1, len);
          for (int j = 0; j < len; j++) m.psum[len - 1 + j] = e[j];
        end
      end
      if (m.idx == n - 1) begin
        m.cw = encode(m.u, 0, n); m.done = 1'b1; m.idx = 0;
      end else begin
        m.idx++;
      end
    end
    return m;
  endfunction

  model_t ms;
  model_t ml;

  initial begin
    ms = model_zero();
    ml = model_zero();
    forever begin
      @(posedge clk);
      if (rst) begin
        ms = model_zero();
        ml = model_zero();
      end else begin
        ms = model_step(ms, SLG, s_if.frame_start, s_if.bit_valid, s_if.decoded_bit);
        ml = model_step(ml, LLG, l_if.frame_start, l_if.bit_valid, l_if.decoded_bit);
      end
      #1;
      check("s_bit_index",  MW'(s_if.bit_index),  MW'(ms.idx));
      check("s_psum_flat",  MW'(s_if.psum_flat),  ms.psum);
      check("s_codeword",   MW'(s_if.codeword),   ms.cw);
      check("s_frame_done", MW'(s_if.frame_done), MW'(ms.done));
      check("l_bit_index",  MW'(l_if.bit_index),  MW'(ml.idx));
      check("l_psum_flat",  MW'(l_if.psum_flat),  ml.psum);
      check("l_codeword",   MW'(l_if.codeword),   ml.cw);
      check("l_frame_done", MW'(l_if.frame_done), MW'(ml.done));
    end
  end

  // One cycle of stimulus on the small (sel=0) or large (sel=1) instance;
  // returns 2 time units after the edge that samples it.
  task automatic drive(input logic sel, input logic fs, input logic v, input logic b);
    @(negedge clk);
    if (sel) begin
      l_if.frame_start = fs; l_if.bit_valid = v; l_if.decoded_bit = b;
    end else begin
      s_if.frame_start = fs; s_if.bit_valid = v; s_if.decoded_bit = b;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send_small(input logic [7:0] bits, input int gap);
    drive(1'b0, 1'b1, 1'b1, bits[0]);
    for (int i = 1; i < 8; i++) begin
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, bits[i]);
    end
  endtask

  task automatic expect_done(input string name, input logic [7:0] cw);
    check({name, "_done"},  MW'(s_if.frame_done), MW'(1'b1));
    check({name, "_cw"},    MW'(s_if.codeword),   MW'(cw));
    check({name, "_index"}, MW'(s_if.bit_index),  MW'(3'd0));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check({name, "_done_drop"}, MW'(s_if.frame_done), MW'(1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the end of stimulus");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted;
    logic v;
    s_if.frame_start = 1'b0; s_if.bit_valid = 1'b0; s_if.decoded_bit = 1'b0;
    l_if.frame_start = 1'b0; l_if.bit_valid = 1'b0; l_if.decoded_bit = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_index", MW'(s_if.bit_index),  MW'(0));
    check("rst_psum",  MW'(s_if.psum_flat),  MW'(0));
    check("rst_cw",    MW'(s_if.codeword),   MW'(0));
    check("rst_done",  MW'(s_if.frame_done), MW'(0));

    // Only u7 reaches x_7 an odd number of times when every u_i is 1.
    send_small(8'hFF, 0); expect_done("all_ones", 8'h80);
    send_small(8'h80, 0); expect_done("only_u7", 8'hFF);
    send_small(8'h01, 0); expect_done("only_u0", 8'h01);

    // Step through u = 1,0,1,1,0,0,0,0 watching each level load.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("p_lvl0_i0", MW'(s_if.psum_flat[0]), MW'(1'b1));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("p_lvl1_i1", MW'(s_if.psum_flat[2:1]), MW'(2'b01));
    check("p_lvl0_i1", MW'(s_if.psum_flat[0]),   MW'(1'b1));
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("p_lvl0_i2", MW'(s_if.psum_flat[0]), MW'(1'b1));
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    // x0=u0^u1^u2^u3=1, x1=u1^u3=1, x2=u2^u3=0, x3=u3=1.
    check("p_lvl2_i3", MW'(s_if.psum_flat[6:3]), MW'(4'b1011));
    for (int i = 4; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    expect_done("partial", 8'h0B);

    // u1,u4,u5,u7 set: x = 8'hDE, with and without bit_valid gaps.
    send_small(8'hB2, 0); expect_done("gapless", 8'hDE);
    send_small(8'hB2, 2); expect_done("gapped",  8'hDE);

    // Restart mid-frame with a valid bit: partial frame discarded.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("restart_index", MW'(s_if.bit_index),      MW'(3'd1));
    check("restart_done",  MW'(s_if.frame_done),     MW'(1'b0));
    check("restart_lvl1",  MW'(s_if.psum_flat[2:1]), MW'(2'b00));
    check("restart_lvl0",  MW'(s_if.psum_flat[0]),   MW'(1'b1));
    check("restart_cw",    MW'(s_if.codeword),       MW'(8'hDE));

    // Asynchronous reset after 5 bits of a fresh frame.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("pre_rst_index", MW'(s_if.bit_index), MW'(3'd5));
    #1 rst = 1'b1;
    #1;
    check("arst_index", MW'(s_if.bit_index),  MW'(0));
    check("arst_psum",  MW'(s_if.psum_flat),  MW'(0));
    check("arst_cw",    MW'(s_if.codeword),   MW'(0));
    check("arst_done",  MW'(s_if.frame_done), MW'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_index", MW'(s_if.bit_index), MW'(0));

    // Random frames on the full-size instance with occasional idle cycles.
    for (int f = 0; f < 20; f++) begin
      drive(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
      accepted = 1;
      while (accepted < (1 << LLG)) begin
        v = ($urandom_range(0, 7) != 0);
        drive(1'b1, 1'b0, v, 1'($urandom_range(0, 1)));
        if (v) accepted++;
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
